int_timer_sched: RTL

// - Periodic wake-up timer scheduler feeding the interrupt controller's timer source.
// - Counts 0.2 s ticks derived from clk_32k. Issues a one-cycle trigger after rg_timer_sel ticks.
// - Supports single-shot and auto-reload modes. Sits beside int_ctrl in the always-on 32 kHz domain.

---
 rtl/int_ctrl_pkg.sv | 13 +
 rtl/int_tick_prescaler.sv | 64 ++++++
 rtl/int_timer_sched.sv | 106 ++++++++++
 3 files changed

// File: rtl/int_ctrl_pkg.sv
// Shared constants and the timer FSM state type used by the interrupt controller timer path.
package int_ctrl_pkg;

  localparam int unsigned TIMER_SEL_MAX  = 300;
  localparam int unsigned TIMER_TICK_DIV = 6554;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } timer_state_e;

endpackage

// File: rtl/int_tick_prescaler.sv
// Divides clk_32k into 0.2 s ticks while run is high; clears whenever run drops.
// Define INT_TIMER_FRAC_EN for the 5-phase fractional divider (exact 1 s per 5 ticks).
module int_tick_prescaler
  import int_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV = TIMER_TICK_DIV
) (
  input  logic clk_32k,
  input  logic rst_n,
  input  logic run,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST_LONG = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] last;

`ifdef INT_TIMER_FRAC_EN
  localparam logic [CNT_W-1:0] LAST_SHORT = CNT_W'(TICK_DIV - 2);

  logic [2:0] phase_q, phase_d;

  // Odd phases (1 and 3) are one cycle short, giving 5*TICK_DIV-2 cycles per 5 ticks.
  always_comb begin
    last    = phase_q[0] ? LAST_SHORT : LAST_LONG;
    phase_d = phase_q;
    if (!run) begin
      phase_d = '0;
    end else if (tick) begin
      phase_d = (phase_q == 3'd4) ? 3'd0 : phase_q + 3'd1;
    end
  end

  always_ff @(posedge clk_32k) begin
    if (!rst_n) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end
`else
  assign last = LAST_LONG;
`endif

  assign tick = run && (cnt_q == last);

  always_comb begin
    cnt_d = '0;
    if (run && !tick) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_32k) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/int_timer_sched.sv
// Periodic wake-up timer: counts rg_timer_sel ticks and emits a one-cycle timer_trig.
// Optional fractional tick divider (macro INT_TIMER_FRAC_EN) lives in int_tick_prescaler.
module int_timer_sched
  import int_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV = TIMER_TICK_DIV,
  parameter int unsigned SEL_W    = 9,
  parameter int unsigned SEL_MAX  = TIMER_SEL_MAX
) (
  input  logic             clk_32k,
  input  logic             rst_n,
  input  logic             rg_timer_on,
  input  logic             rg_timer_mode,
  input  logic [SEL_W-1:0] rg_timer_sel,
  output logic             timer_trig,
  output logic             timer_busy,
  output logic [SEL_W-1:0] timer_remain
);

  timer_state_e     state_q, state_d;
  logic [SEL_W-1:0] remain_q, remain_d;
  logic [SEL_W-1:0] sel_eff;
  logic             trig_q, trig_d;
  logic             run, tick, last_tick;

  assign run       = (state_q == RUN) && rg_timer_on;
  assign last_tick = (remain_q <= SEL_W'(1));

  int_tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk_32k (clk_32k),
    .rst_n   (rst_n),
    .run     (run),
    .tick    (tick)
  );

  // Out-of-range periods are silently clamped to [1, SEL_MAX].
  always_comb begin
    if (rg_timer_sel == '0) begin
      sel_eff = SEL_W'(1);
    end else if (rg_timer_sel > SEL_W'(SEL_MAX)) begin
      sel_eff = SEL_W'(SEL_MAX);
    end else begin
      sel_eff = rg_timer_sel;
    end
  end

  always_ff @(posedge clk_32k) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      remain_q <= '0;
      trig_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      trig_q   <= trig_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    unique case (state_q)
      IDLE: begin
        if (rg_timer_on) begin
          state_d  = RUN;
          remain_d = sel_eff;
        end
      end
      RUN: begin
        if (!rg_timer_on) begin
          state_d  = IDLE;
          remain_d = '0;
        end else if (tick) begin
          if (!last_tick) begin
            remain_d = remain_q - SEL_W'(1);
          end else if (rg_timer_mode) begin
            remain_d = sel_eff;
          end else begin
            state_d  = DONE;
            remain_d = '0;
          end
        end
      end
      DONE: begin
        if (!rg_timer_on) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d  = IDLE;
        remain_d = '0;
      end
    endcase
  end

  // A stop on the expiring tick suppresses the trigger because run is already low.
  always_comb begin
    timer_busy   = (state_q == RUN);
    timer_remain = timer_busy ? remain_q : '0;
    timer_trig   = trig_q;
    trig_d       = run && tick && last_tick;
  end

endmodule
